// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//   APB4 requester. A valid/ready command port starts one APB transfer at a
//   time and a valid/ready response port returns read data and error status.
//   Transfers follow SETUP -> ACCESS with any number of pready wait states.
//
// Optional feature (compile-time macro):
//   APB_MASTER_TIMEOUT_EN - abort an ACCESS phase that sees no pready for
//                           TIMEOUT_CYCLES cycles, and report it as an error.
//                           When undefined the master waits indefinitely.
//
// Parameters:
//   DATA_WIDTH     APB data width (8, 16 or 32)
//   ADDR_WIDTH     APB address width (8, 16 or 32)
//   TIMEOUT_CYCLES ACCESS cycles without pready before abort (min 2)
//
// Ports:
//   pclk, preset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = in IDLE)
//   cmd_write/addr/wdata/strb command fields, captured on acceptance
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       read data (0 for writes), slave error/timeout
//   paddr..pstrb, psel,
//   penable                  APB requester outputs (all registered)
//   pready, prdata, pslverr  APB completer inputs, sampled only in ACCESS
// ---------------------------------------------------------------------------
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_paddr,     w_paddr_nxt;
  logic                  r_psel,      w_psel_nxt;
  logic                  r_penable,   w_penable_nxt;
  logic                  r_pwrite,    w_pwrite_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata,    w_pwdata_nxt;
  logic [STRB_W-1:0]     r_pstrb,     w_pstrb_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err,   w_rsp_err_nxt;

  // High in the ACCESS cycle that gives up waiting for pready.
  logic                  w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  // At least 8 bits wide; wider only when the limit needs it.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] w_to_cnt_nxt;

  // Wait-state counter: cleared on the way into ACCESS, counts pready-low cycles.
  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    case (r_state)
      ST_SETUP: w_to_cnt_nxt = {CNT_W{1'b0}};
      ST_ACCESS: begin
        if (!pready) begin
          w_to_cnt_nxt = r_to_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_to_cnt_nxt = r_to_cnt;
        end
      end
      default: w_to_cnt_nxt = r_to_cnt;
    endcase
  end

  // Wait-state counter register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_to_cnt <= {CNT_W{1'b0}};
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
    end
  end

  // pready in the limit cycle still completes normally, so it masks the abort.
  assign w_timeout = (r_state == ST_ACCESS) && !pready && (r_to_cnt == TO_LIMIT);
`else
  assign w_timeout = 1'b0;
`endif

  // State register plus all registered outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= ST_IDLE;
      r_paddr     <= {ADDR_WIDTH{1'b0}};
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= {DATA_WIDTH{1'b0}};
      r_pstrb     <= {STRB_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_paddr     <= w_paddr_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pstrb     <= w_pstrb_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (pready || w_timeout) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed.
  always_comb begin
    w_paddr_nxt     = r_paddr;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_pwdata_nxt    = r_pwdata;
    w_pstrb_nxt     = r_pstrb;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_paddr_nxt   = cmd_addr;
          w_pwrite_nxt  = cmd_write;
          w_pwdata_nxt  = cmd_wdata;
          // Reads must present all-zero strobes on APB4.
          w_pstrb_nxt   = cmd_write ? cmd_strb : {STRB_W{1'b0}};
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
        end else begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        w_penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_rsp_rdata_nxt = r_pwrite ? {DATA_WIDTH{1'b0}} : prdata;
          w_rsp_err_nxt   = pslverr;
          w_rsp_valid_nxt = 1'b1;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
        end else if (w_timeout) begin
          w_rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
        end else begin
          w_psel_nxt      = r_psel;
          w_penable_nxt   = r_penable;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
        end else begin
          w_rsp_valid_nxt = r_rsp_valid;
        end
      end
      default: begin
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // The only combinational output: forced low while reset is asserted.
  assign cmd_ready = (r_state == ST_IDLE) && !preset;

  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: randomized and directed APB transfers, a completer
// model that follows a per-transfer plan (wait states, error, read data), and
// a response scoreboard fed by an abstract transfer model.
module tb_apb_master;

  localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_strb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        pslverr = 1'b0;

  apb_master dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;   // pready-low ACCESS cycles the completer inserts
    logic        err;
    logic [31:0] rd;
    int          acc;     // cycle count just before the accepting edge
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cycles;
    int          acc;
  } rsp_t;

  txn_t apb_q[$];
  rsp_t rsp_q[$];
  int   rises[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rsp_mode = 0;   // 0 random rsp_ready, 1 always ready, 2 hold low 5 cycles
  bit flush = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Abstract transfer outcome: ACCESS lasts waits+1 cycles unless the timeout
  // cuts it to TO cycles; response appears after SETUP + ACCESS + 1 register.
  function automatic rsp_t model(input txn_t t);
    rsp_t r;
    bit   aborted;
    aborted      = TO_EN && (t.waits >= TO);
    r.acc_cycles = aborted ? TO : t.waits + 1;
    r.lat        = 2 + r.acc_cycles;
    r.err        = aborted ? 1'b1 : t.err;
    r.rdata      = (aborted || t.wr) ? 32'h0 : t.rd;
    r.acc        = t.acc;
    return r;
  endfunction

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int waits, input logic err,
                       input logic [31:0] rd);
    txn_t t;
    int   guard;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    #1;
    guard = 0;
    while (!cmd_ready && guard < 300) begin
      @(negedge pclk); #1; guard++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 1'b0, 1'b1);
    end else begin
      t.wr = wr; t.addr = a; t.wdata = d; t.strb = s; t.waits = waits;
      t.err = err; t.rd = rd; t.acc = cyc;
      apb_q.push_back(t);
      rsp_q.push_back(model(t));
      @(posedge pclk);
    end
    #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_strb = 4'($urandom);
  endtask

  task automatic drain(input int limit);
    int g;
    g = 0;
    while (rsp_q.size() != 0 && g < limit) begin
      @(negedge pclk); g++;
    end
    check("drain", rsp_q.size(), 0);
    repeat (2) @(negedge pclk);
  endtask

  // Completer model and APB-side checks.
  txn_t cur;
  rsp_t cur_r;
  bit   active = 1'b0;
  int   acc_cnt = 0;
  int   rise_cyc = 0;
  logic psel_q = 1'b0;
  initial begin
    forever begin
      @(negedge pclk);
      check("apb_proto", {penable && !psel, psel && rsp_valid}, 2'b00);
      if (psel && !psel_q) begin
        rises.push_back(cyc);
        if (apb_q.size() == 0) begin
          check("psel_unexpected", 1'b1, 1'b0);
        end else begin
          cur = apb_q.pop_front();
          cur_r = model(cur);
          check("psel_rise_cycle", cyc - cur.acc, 1);
          check("setup_penable", penable, 1'b0);
          active = 1'b1; acc_cnt = 0; rise_cyc = cyc;
        end
      end
      if (psel && penable && active) begin
        if (acc_cnt == 0) check("access_start", cyc - rise_cyc, 1);
        check("apb_fields", {paddr, pwrite, pwdata, pstrb},
              {cur.addr, cur.wr, cur.wdata, (cur.wr ? cur.strb : 4'h0)});
        pready  = (acc_cnt == cur.waits);
        pslverr = pready ? cur.err : 1'($urandom);
        prdata  = pready ? cur.rd : $urandom;
        acc_cnt++;
      end else begin
        if (active && !psel) begin
          if (!flush) check("access_cycles", acc_cnt, cur_r.acc_cycles);
          active = 1'b0;
        end
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
      psel_q = psel;
    end
  end

  // Response monitor / scoreboard.
  rsp_t        exp_r;
  bit          in_rsp = 1'b0;
  bit          hs_prev = 1'b0;
  int          hold = 0;
  logic [31:0] h_rdata = 32'h0;
  logic        h_err = 1'b0;
  initial begin
    forever begin
      @(negedge pclk);
      if (hs_prev) begin
        check("post_handshake", {rsp_valid, cmd_ready}, 2'b01);
        hs_prev = 1'b0;
      end
      if (rsp_valid) begin
        check("cmd_ready_in_resp", cmd_ready, 1'b0);
        if (!in_rsp) begin
          in_rsp = 1'b1; hold = 0;
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 1'b1, 1'b0);
          end else begin
            exp_r = rsp_q.pop_front();
            check("rsp_latency", cyc - exp_r.acc, exp_r.lat);
            check("rsp_rdata", rsp_rdata, exp_r.rdata);
            check("rsp_err", rsp_err, exp_r.err);
          end
          h_rdata = rsp_rdata; h_err = rsp_err;
        end else begin
          check("rsp_stable", {rsp_rdata, rsp_err}, {h_rdata, h_err});
        end
        case (rsp_mode)
          0:       rsp_ready = ($urandom_range(0, 2) != 0);
          1:       rsp_ready = 1'b1;
          default: rsp_ready = (hold >= 5);
        endcase
        hold++;
        if (rsp_ready) begin
          hs_prev = 1'b1; in_rsp = 1'b0;
        end
      end else begin
        in_rsp = 1'b0;
        rsp_ready = (rsp_mode == 1) ? 1'b1 : 1'($urandom);
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int g;
    preset = 1'b1;
    repeat (3) begin
      @(negedge pclk); #1;
      check("reset_outputs", {psel, penable, pwrite, paddr, pwdata, pstrb,
                              rsp_valid, rsp_rdata, rsp_err, cmd_ready}, 128'h0);
    end
    @(negedge pclk);
    preset = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1'b1);

    // Write, zero wait states.
    rsp_mode = 1;
    issue(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, $urandom);
    drain(50);

    // Read with 3 wait states; strobes must be forced to zero.
    rsp_mode = 0;
    issue(1'b0, 32'h0000_1230, $urandom, 4'hF, 3, 1'b0, 32'h1234_5678);
    drain(50);

    // Slave error with response backpressure.
    rsp_mode = 2;
    issue(1'b0, 32'h0000_1238, $urandom, 4'h5, 1, 1'b1, 32'hA5A5_5A5A);
    drain(50);

    // Back-to-back commands.
    rsp_mode = 1;
    rises.delete();
    issue(1'b1, 32'h0000_1240, 32'h0BAD_F00D, 4'h3, 0, 1'b0, $urandom);
    issue(1'b0, 32'h0000_1244, $urandom, 4'hC, 0, 1'b0, 32'hCAFE_0001);
    drain(50);
    check("b2b_rise_count", rises.size(), 2);
    if (rises.size() == 2) check("b2b_spacing", rises[1] - rises[0], 4);

    // Long waits: last cycle before the timeout limit, then well past it.
    rsp_mode = 0;
    issue(1'b0, 32'h0000_1250, $urandom, 4'h1, TO - 1, 1'b0, 32'h5555_AAAA);
    drain(100);
    issue(1'b0, 32'h0000_1254, $urandom, 4'h1, 120, 1'b0, 32'h7777_1111);
    drain(300);

    // Randomized traffic with queued commands.
    for (int i = 0; i < 24; i++) begin
      rsp_mode = int'($urandom_range(0, 2));
      issue(1'($urandom), $urandom, $urandom, 4'($urandom),
            int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), $urandom);
    end
    drain(400);

    // Reset while waiting in ACCESS.
    rsp_mode = 0;
    issue(1'b0, 32'h0000_1260, $urandom, 4'h3, 50, 1'b0, $urandom);
    g = 0;
    while (!(psel && penable) && g < 20) begin
      @(negedge pclk); g++;
    end
    check("reach_access", psel && penable, 1'b1);
    repeat (2) @(negedge pclk);
    flush = 1'b1;
    preset = 1'b1;
    #1;
    check("ready_low_in_reset", cmd_ready, 1'b0);
    @(negedge pclk);
    preset = 1'b0;
    check("reset_mid_access", {psel, penable, pwrite, paddr, pwdata, pstrb,
                               rsp_valid, rsp_rdata, rsp_err}, 128'h0);
    #1;
    check("ready_after_midreset", cmd_ready, 1'b1);
    rsp_q.delete();
    apb_q.delete();
    repeat (6) begin
      @(negedge pclk);
      check("no_rsp_after_reset", rsp_valid, 1'b0);
    end
    flush = 1'b0;

    // Recovery after reset.
    issue(1'b1, 32'h0000_1270, 32'h1357_9BDF, 4'h9, 2, 1'b0, $urandom);
    drain(50);

    check("scoreboard_empty", rsp_q.size() + apb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
